recepcao_serial_automatica_fd: RTL

//  Receive side of the elevator serial link. Deserialises 7O1 frames on RX:
//  1 start bit, 7 data bits LSB first, odd parity, 1 stop bit.

---
 rtl/smartcargo_pkg.sv | 16 +
 rtl/recepcao_serial_automatica_fd_rx.sv | 94 +++++++++
 rtl/recepcao_serial_automatica_fd.sv | 96 +++++++++
 3 files changed

// File: rtl/smartcargo_pkg.sv
// Shared types and constants for the SmartCargo serial receive path.
package smartcargo_pkg;

  localparam int unsigned FRAME_DATA_BITS = 7;
  localparam logic [2:0]  CONTEUDO_PREFIX = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } frame_state_t;

endpackage

// File: rtl/recepcao_serial_automatica_fd_rx.sv
// 7O1 deserialiser: RX synchroniser, bit timer and frame FSM.
// Reports the captured data with parity/stop status for one cycle per frame.
module rx_serial_7O1
  import smartcargo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       RX,
  output logic [FRAME_DATA_BITS-1:0] dados,
  output logic                       recebido,
  output logic                       paridade_ok,
  output logic                       stop_ok
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  frame_state_t               state, state_nx;
  logic                       rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]           cnt;
  logic [2:0]                 bit_idx;
  logic [FRAME_DATA_BITS-1:0] shift;
  logic                       par_bit;
  logic                       fall_c, tick_c;

  // Synchroniser and edge-detect history; idle level is high so no false edge out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Edge-based arming also covers a bad stop bit: the line must return high first.
  always_comb begin
    state_nx = state;
    fall_c   = rx_prev & ~rx_sync;
    tick_c   = (state == START) ? (cnt == CNT_W'(HALF - 1))
                                : (cnt == CNT_W'(CLKS_PER_BIT - 1));
    case (state)
      IDLE:    if (fall_c) state_nx = START;
      START:   if (tick_c) state_nx = rx_sync ? IDLE : DATA;
      DATA:    if (tick_c && bit_idx == 3'(FRAME_DATA_BITS - 1)) state_nx = PARITY;
      PARITY:  if (tick_c) state_nx = STOP;
      STOP:    if (tick_c) state_nx = DONE;
      DONE:    state_nx = fall_c ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit timer, shift register and frame result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      dados       <= '0;
      recebido    <= 1'b0;
      paridade_ok <= 1'b0;
      stop_ok     <= 1'b0;
    end else begin
      recebido <= 1'b0;
      if (state == IDLE || state_nx != state || tick_c) cnt <= '0;
      else                                              cnt <= cnt + CNT_W'(1);

      if (state == START)              bit_idx <= '0;
      else if (state == DATA && tick_c) bit_idx <= bit_idx + 3'd1;

      if (state == DATA && tick_c)   shift   <= {rx_sync, shift[FRAME_DATA_BITS-1:1]};
      if (state == PARITY && tick_c) par_bit <= rx_sync;

      if (state == STOP && tick_c) begin
        dados       <= shift;
        paridade_ok <= ^{shift, par_bit};
        stop_ok     <= rx_sync;
        recebido    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/recepcao_serial_automatica_fd.sv
// Receive side of the elevator serial link: classifies 7O1 frames into fila/conteudo RAM writes.
// Build option: RX_PARITY_CHECK_EN enforces odd parity; otherwise parity is ignored.
module recepcao_serial_automatica_fd
  import smartcargo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned N_FILA       = 15,
  parameter int unsigned N_CONTEUDO   = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       zera_enderecos,
  output logic [5:0] dados_fila_elevador,
  output logic [3:0] addr_fila_elevador,
  output logic       we_fila_elevador,
  output logic [3:0] dados_conteudo_elevador,
  output logic [3:0] addr_conteudo_elevador,
  output logic       we_conteudo_elevador,
  output logic       fim_recepcao_fila,
  output logic       fim_recepcao_conteudo,
  output logic       erro_paridade,
  output logic       erro_formato
);

  logic [FRAME_DATA_BITS-1:0] dados;
  logic                       recebido, paridade_ok, stop_ok;
  logic                       is_fila_c, is_cont_c, par_err_c, frame_ok_c;
  logic                       wr_fila_c, wr_cont_c, fmt_err_c;
  logic [3:0]                 cnt_fila_nx, cnt_cont_nx;

  rx_serial_7O1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .RX         (RX),
    .dados      (dados),
    .recebido   (recebido),
    .paridade_ok(paridade_ok),
    .stop_ok    (stop_ok)
  );

`ifdef RX_PARITY_CHECK_EN
  assign par_err_c = ~paridade_ok;
`else
  logic paridade_unused;
  assign paridade_unused = paridade_ok;
  assign par_err_c       = 1'b0;
`endif

  // The address outputs are the counters: during a strobe they still hold the pre-increment value.
  always_comb begin
    is_fila_c  = ~dados[6];
    is_cont_c  = (dados[6:4] == CONTEUDO_PREFIX);
    frame_ok_c = recebido & stop_ok & ~par_err_c;
    wr_fila_c  = frame_ok_c & is_fila_c & ~fim_recepcao_fila;
    wr_cont_c  = frame_ok_c & is_cont_c & ~fim_recepcao_conteudo;
    fmt_err_c  = recebido & (~stop_ok | (~is_fila_c & ~is_cont_c));

    cnt_fila_nx = addr_fila_elevador;
    if (zera_enderecos)        cnt_fila_nx = '0;
    else if (we_fila_elevador) cnt_fila_nx = addr_fila_elevador + 4'd1;

    cnt_cont_nx = addr_conteudo_elevador;
    if (zera_enderecos)            cnt_cont_nx = '0;
    else if (we_conteudo_elevador) cnt_cont_nx = addr_conteudo_elevador + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_fila_elevador     <= '0;
      addr_fila_elevador      <= '0;
      we_fila_elevador        <= 1'b0;
      dados_conteudo_elevador <= '0;
      addr_conteudo_elevador  <= '0;
      we_conteudo_elevador    <= 1'b0;
      fim_recepcao_fila       <= 1'b0;
      fim_recepcao_conteudo   <= 1'b0;
      erro_paridade           <= 1'b0;
      erro_formato            <= 1'b0;
    end else begin
      we_fila_elevador       <= wr_fila_c;
      we_conteudo_elevador   <= wr_cont_c;
      erro_paridade          <= recebido & stop_ok & par_err_c;
      erro_formato           <= fmt_err_c;
      addr_fila_elevador     <= cnt_fila_nx;
      addr_conteudo_elevador <= cnt_cont_nx;
      fim_recepcao_fila      <= (cnt_fila_nx == 4'(N_FILA));
      fim_recepcao_conteudo  <= (cnt_cont_nx == 4'(N_CONTEUDO));
      if (wr_fila_c) dados_fila_elevador     <= dados[5:0];
      if (wr_cont_c) dados_conteudo_elevador <= dados[3:0];
    end
  end

endmodule
